// File: rtl/m_tx_frame_arbiter.sv
`timescale 1ns/1ps
// Frame-level round-robin arbiter feeding the transmitter byte/push interface.
// Latency: grant 1 cycle after request in IDLE; accepted byte on o_tx_data 1 cycle later; push 1 cycle after last write.
// Backpressure: ready only toward the frame owner while streaming; new grants stall while transmitter holds MAX_PENDING frames.
module m_tx_frame_arbiter #(
    parameter int MAX_PENDING   = 4,
    parameter int MAX_FRAME_LEN = 256,
    parameter int SETTLE_CYC    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_req_valid,
    input  logic [1:0]  i_req_last,
    input  logic [7:0]  i_req_data0,
    input  logic [7:0]  i_req_data1,
    output logic [1:0]  o_req_ready,
    input  logic [7:0]  i_tx_frames_count,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_data_we,
    output logic        o_tx_push_frame,
    output logic [1:0]  o_grant,
    output logic        o_busy,
    output logic [15:0] o_frames_sent,
    output logic        o_trunc_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_PUSH   = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    // Byte counter must reach MAX_FRAME_LEN itself, hence the +1.
    localparam int LEN_W = $clog2(MAX_FRAME_LEN + 1);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    localparam logic [7:0]       PEND_LIM    = 8'(MAX_PENDING);
    localparam logic [LEN_W-1:0] LEN_LIM     = LEN_W'(MAX_FRAME_LEN);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             rr_ptr;       // requester preferred at the next contested grant
    logic [LEN_W-1:0] byte_cnt;     // bytes written to the transmitter this frame
    logic             trunc_flag;   // current frame has lost bytes past the budget
    logic [SET_W-1:0] settle_cnt;

    logic       cnt_ok;
    logic       start;
    logic       pick;
    logic       accept;
    logic       accept_last;
    logic       in_budget;
    logic [7:0] sel_data;
    logic       settle_done;

    // Ready depends only on state and owner so a requester never sees a combinational loop.
    assign o_req_ready = (state == ST_STREAM) ? o_grant : 2'b00;
    assign o_busy      = (state != ST_IDLE);

    assign cnt_ok      = (i_tx_frames_count < PEND_LIM);
    assign start       = (state == ST_IDLE) && cnt_ok && (|i_req_valid);
    // If the preferred requester is quiet the other one takes the slot.
    assign pick        = i_req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;

    assign accept      = |(i_req_valid & o_req_ready);
    assign accept_last = |(i_req_valid & i_req_last & o_req_ready);
    assign in_budget   = (byte_cnt < LEN_LIM);
    assign sel_data    = o_grant[1] ? i_req_data1 : i_req_data0;
    assign settle_done = (settle_cnt == SETTLE_LAST);

    // Frame sequencing: one whole frame per grant, then push and let the count settle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_STREAM;
            ST_STREAM: if (accept_last) state_nxt = ST_PUSH;
            ST_PUSH:   state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_done) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner register and round-robin pointer; owner is held until the settle window ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_grant <= 2'b00;
            rr_ptr  <= 1'b0;
        end else if (start) begin
            o_grant <= pick ? 2'b10 : 2'b01;
            rr_ptr  <= ~pick;
        end else if ((state == ST_SETTLE) && settle_done) begin
            o_grant <= 2'b00;
        end
    end

    // Write path: accepted in-budget bytes go out one cycle later; data holds otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tx_data    <= 8'h00;
            o_tx_data_we <= 1'b0;
        end else begin
            o_tx_data_we <= accept && in_budget;
            if (accept && in_budget) begin
                o_tx_data <= sel_data;
            end
        end
    end

    // Per-frame byte budget; over-budget bytes are still consumed but only mark truncation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_cnt   <= '0;
            trunc_flag <= 1'b0;
        end else if (state == ST_PUSH) begin
            byte_cnt   <= '0;
            trunc_flag <= 1'b0;
        end else if (accept) begin
            if (in_budget) begin
                byte_cnt <= byte_cnt + LEN_W'(1);
            end else begin
                trunc_flag <= 1'b1;
            end
        end
    end

    // Push pulse, frame counter and truncation report all line up on the cycle after PUSH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tx_push_frame <= 1'b0;
            o_trunc_err     <= 1'b0;
            o_frames_sent   <= 16'h0000;
        end else begin
            o_tx_push_frame <= (state == ST_PUSH);
            o_trunc_err     <= (state == ST_PUSH) && trunc_flag;
            if (state == ST_PUSH) begin
                o_frames_sent <= o_frames_sent + 16'd1;
            end
        end
    end

    // Settle window length so the transmitter's pending count reflects the new frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            settle_cnt <= '0;
        end else if (state == ST_SETTLE) begin
            settle_cnt <= settle_cnt + SET_W'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

endmodule
